audio_sample_feeder: RTL and testbench
======================================

# audio_sample_feeder

Stereo sample buffer that sits directly upstream of the I2S signal generator in the synthesizer block. It accepts left/right PCM sample pairs from the voice mixer over a valid/ready handshake and stores them in a small FIFO. It pops one pair per I2S frame on the generator's one-shot ready pulse, and presents the correct channel word on the generator's 32-bit data input. On underrun it substitutes silence, so the DAC never sees stale or garbage data.

## Interface
Parameters:
- pDepth, 16: FIFO depth in stereo pairs; power of two, minimum 4.
- pSampleWidth, 24: signed PCM sample width; legal range 16..32.

Ports:
- iMCLK  in  1  audio master clock; the block runs on rising edges only.
- iMRSTn  in  1  reset; asynchronous assert, active-low.
- iSampleL  in  pSampleWidth  signed left sample from the mixer.
- iSampleR  in  pSampleWidth  signed right sample from the mixer.
- iSampleValid  in  1  the L/R pair is valid.
- oSampleReady  out  1  the FIFO can accept a pair (not full).
- iMute  in  1  level; forces silence on subsequent pops.
- oAudioData  out  32  word for the I2S generator's next channel load.
- iAudioDataRdy  in  1  one-cycle pulse from the I2S generator, once per frame.
- iI2S_LRCLK  in  1  LR clock from the I2S generator; 1 means the next load is the left word.
- oFillLevel  out  clog2(pDepth)+1  number of stored pairs.
- oUnderrunCnt  out  16  saturating underrun count (see Configuration).

## Operation
- Write side: a pair is pushed when iSampleValid & oSampleReady are both high at the rising edge. The pushed pair is visible in oFillLevel on the next cycle.
- oSampleReady = (oFillLevel != pDepth). It is a registered full flag. A push offered while full is not accepted, even if a pop happens in the same cycle.
- Pop: occurs on a rising edge where iAudioDataRdy = 1.
  - FIFO not empty: the head pair is loaded into the holding registers rHoldL/rHoldR.
  - FIFO empty (underrun): both holding registers are loaded with 0 and the underrun counter increments.
- Mute: when iMute = 1 at a pop, a non-empty FIFO is still popped, but the holding registers load 0. Mute does not count as an underrun.
- Simultaneous push and pop:
  - Not full, not empty: both take effect and oFillLevel is unchanged.
  - Empty: the pop is an underrun and the pushed pair is stored; oFillLevel goes 0→1.
- Word format: each sample is MSB-aligned in 32 bits, i.e. {sample, (32-pSampleWidth) zeros}. Sign is preserved with no rounding or saturation. The bit-order rotation required by the DAC belongs to the I2S generator, not this block.
- Channel select: oAudioData = iI2S_LRCLK ? fmt(rHoldL) : fmt(rHoldR). It is registered, so it updates one cycle after iI2S_LRCLK or the holding registers change.
- The fill counter wraps nowhere. Read and write pointers are clog2(pDepth) bits wide and wrap naturally modulo pDepth.

## Timing
- Reset values:
  - oAudioData = 0, oSampleReady = 1, oFillLevel = 0, oUnderrunCnt = 0.
  - rHoldL = rHoldR = 0; both pointers at 0.
- The FIFO storage array is not reset.
- Pop latency: iAudioDataRdy high at edge N → holding registers valid after edge N, oAudioData valid after edge N+1. The generator's next channel load is more than 100 MCLK cycles later, so the margin is ample.
- iAudioDataRdy and iI2S_LRCLK are launched on falling edges of iMCLK by the generator, giving a half-cycle path into this block. No synchronizers are used: both sides share the same clock.
- iAudioDataRdy is a one-cycle pulse. If it is held high for k cycles, k pops occur; no edge detection is applied.
- Reset asserted mid-frame: all state clears immediately, and oAudioData drops to 0 asynchronously.

## Configuration
- AUDIO_FEEDER_UNDERRUN_CNT_EN defined: oUnderrunCnt is a 16-bit counter that increments once per underrun pop and saturates at 16'hFFFF. It clears only on reset.
- Not defined: the counter logic is omitted and oUnderrunCnt is tied to 16'h0000. The port is still present.

## Structure
- Shared package holds:
  - the 32-bit I2S word width constant
  - the underrun counter width (16)
  - the MSB-align format function fmt()
- One sub-module: audio_pair_fifo. It is a synchronous FIFO of {L,R} pairs with push/pop, full/empty and level outputs, using simple dual-port RAM inference with registered read.
- The top level contains the holding registers, mute/underrun muxing, the channel-select output register and the counter.

## Test plan
- Reset, then one Rdy pulse with the FIFO empty → oAudioData = 0 for both LRCLK levels; oUnderrunCnt = 1 (macro on) or 0 (macro off).
- Push L=24'h123456, R=24'hFEDCBA, then Rdy → LRCLK=1 gives 32'h12345600; LRCLK=0 gives 32'hFEDCBA00; oFillLevel returns to 0.
- Push 16 pairs with no Rdy → oSampleReady = 0 and oFillLevel = 16; a 17th push is ignored. Then 16 Rdy pulses return the pairs in order and a 17th pulse underruns.
- With oFillLevel = 0, push and Rdy in the same cycle → underrun counted; oFillLevel = 1; the next Rdy outputs the pushed pair.
- iMute = 1 with 3 pairs queued, then Rdy → output 0; oFillLevel = 2; counter unchanged. Deassert mute, then Rdy → second pair is output.
- Assert iMRSTn low while oAudioData ≠ 0 → oAudioData = 0 immediately; after release, oSampleReady = 1 and oFillLevel = 0.

Source files
------------

// File: rtl/audio_sample_feeder_pkg.sv
// Shared constants and the I2S word formatting helper for the audio sample feeder.
package audio_sample_feeder_pkg;

  // Width of one channel word handed to the I2S generator.
  localparam int unsigned I2S_WORD_W = 32;
  // Width of the saturating underrun counter.
  localparam int unsigned UNDERRUN_CNT_W = 16;

  // MSB-align a zero-extended sample of sample_w bits into an I2S word.
  // The sample's sign bit lands in bit 31; the low bits are filled with zeros.
  function automatic logic [I2S_WORD_W-1:0] fmt(input logic [I2S_WORD_W-1:0] sample_zx,
                                               input int unsigned sample_w);
    return sample_zx << (I2S_WORD_W - sample_w);
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO of {L,R} sample pairs. The storage array is written on push
// and read through a registered port that always holds the head entry, with a
// write bypass so a pair pushed into an empty FIFO is at the head next cycle.
module audio_pair_fifo #(
  parameter int unsigned pDepth = 16,
  parameter int unsigned pWidth = 48
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [pWidth-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [pWidth-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(pDepth):0]    level_o
);

  localparam int unsigned AW = $clog2(pDepth);

  logic [pWidth-1:0] mem_q [pDepth];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              full_q, full_d;
  logic [pWidth-1:0] rdata_q, rdata_d;
  logic              push_ok_s, pop_ok_s;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push_ok_s = push_i & ~full_q;
  assign pop_ok_s  = pop_i & (level_q != {(AW+1){1'b0}});

  // Next-state for pointers, level, full flag and the head-entry read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == (AW+1)'(pDepth));
    // The slot being written becomes the head only when the FIFO is empty after the pop.
    if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      rdata_d = wdata_i;
    end else begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  // Pair storage; intentionally not reset so it maps onto dual-port RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer, level, full flag and read-port registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
      full_q   <= 1'b0;
      rdata_q  <= {pWidth{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign full_o  = full_q;
  assign empty_o = (level_q == {(AW+1){1'b0}});
  assign level_o = level_q;

endmodule

// File: rtl/audio_sample_feeder.sv
// Stereo sample buffer feeding the I2S generator: queues L/R pairs from the
// mixer, pops one pair per frame on the generator's ready pulse, and outputs
// silence on mute or underrun.
// Optional feature: define AUDIO_FEEDER_UNDERRUN_CNT_EN to build the
// saturating underrun counter; otherwise oUnderrunCnt is tied to zero.
module audio_sample_feeder
  import audio_sample_feeder_pkg::*;
#(
  parameter int unsigned pDepth       = 16,
  parameter int unsigned pSampleWidth = 24
) (
  input  logic                        iMCLK,
  input  logic                        iMRSTn,
  input  logic [pSampleWidth-1:0]     iSampleL,
  input  logic [pSampleWidth-1:0]     iSampleR,
  input  logic                        iSampleValid,
  output logic                        oSampleReady,
  input  logic                        iMute,
  output logic [I2S_WORD_W-1:0]       oAudioData,
  input  logic                        iAudioDataRdy,
  input  logic                        iI2S_LRCLK,
  output logic [$clog2(pDepth):0]     oFillLevel,
  output logic [UNDERRUN_CNT_W-1:0]   oUnderrunCnt
);

  logic [2*pSampleWidth-1:0] fifo_rdata_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [pSampleWidth-1:0]   hold_l_q, hold_l_d;
  logic [pSampleWidth-1:0]   hold_r_q, hold_r_d;
  logic [I2S_WORD_W-1:0]     audio_q, audio_d;

  audio_pair_fifo #(
    .pDepth (pDepth),
    .pWidth (2*pSampleWidth)
  ) u_fifo (
    .clk_i   (iMCLK),
    .rst_ni  (iMRSTn),
    .push_i  (iSampleValid),
    .wdata_i ({iSampleL, iSampleR}),
    .pop_i   (iAudioDataRdy),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (oFillLevel)
  );

  assign oSampleReady = ~fifo_full_s;

  // Holding register load on a pop, and channel select from the current holding pair.
  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (iAudioDataRdy) begin
      if (fifo_empty_s || iMute) begin
        hold_l_d = {pSampleWidth{1'b0}};
        hold_r_d = {pSampleWidth{1'b0}};
      end else begin
        {hold_l_d, hold_r_d} = fifo_rdata_s;
      end
    end else begin
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
    end
    if (iI2S_LRCLK) begin
      audio_d = fmt(I2S_WORD_W'(hold_l_q), pSampleWidth);
    end else begin
      audio_d = fmt(I2S_WORD_W'(hold_r_q), pSampleWidth);
    end
  end

  // Holding registers and the registered channel word.
  always_ff @(posedge iMCLK or negedge iMRSTn) begin
    if (!iMRSTn) begin
      hold_l_q <= {pSampleWidth{1'b0}};
      hold_r_q <= {pSampleWidth{1'b0}};
      audio_q  <= {I2S_WORD_W{1'b0}};
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      audio_q  <= audio_d;
    end
  end

  assign oAudioData = audio_q;

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  logic                      underrun_s;
  logic [UNDERRUN_CNT_W-1:0] urun_cnt_q, urun_cnt_d;

  assign underrun_s = iAudioDataRdy & fifo_empty_s;

  // Saturating count of pops that found the FIFO empty.
  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (underrun_s && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_d = urun_cnt_q + 16'h0001;
    end else begin
      urun_cnt_d = urun_cnt_q;
    end
  end

  // Underrun counter register; cleared only by reset.
  always_ff @(posedge iMCLK or negedge iMRSTn) begin
    if (!iMRSTn) begin
      urun_cnt_q <= 16'h0000;
    end else begin
      urun_cnt_q <= urun_cnt_d;
    end
  end

  assign oUnderrunCnt = urun_cnt_q;
`else
  assign oUnderrunCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder (default parameters) against a
// queue-based reference model of the sample buffer.
module tb_audio_sample_feeder;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [23:0] sl, sr;
  logic        valid, mute, rdy, lr;
  logic        ready;
  logic [31:0] audio;
  logic [4:0]  fill;
  logic [15:0] ucnt;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [47:0] m_q[$];
  logic [23:0] m_hl, m_hr;
  int          m_cnt;
  logic [31:0] m_audio;

  audio_sample_feeder dut (
    .iMCLK         (clk),
    .iMRSTn        (rst_n),
    .iSampleL      (sl),
    .iSampleR      (sr),
    .iSampleValid  (valid),
    .oSampleReady  (ready),
    .iMute         (mute),
    .oAudioData    (audio),
    .iAudioDataRdy (rdy),
    .iI2S_LRCLK    (lr),
    .oFillLevel    (fill),
    .oUnderrunCnt  (ucnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [23:0] s);
    return {s, 8'h00};
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready", 32'(ready), 32'(m_q.size() != DEPTH));
    chk("fill",  32'(fill),  32'(m_q.size()));
    chk("ucnt",  32'(ucnt),  exp_cnt());
    chk("audio", audio,      m_audio);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hl = 24'h0; m_hr = 24'h0;
    m_cnt = 0;
    m_audio = 32'h0;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 time unit later.
  task automatic step(input logic v, input logic [23:0] l, input logic [23:0] r,
                      input logic rd, input logic mu, input logic lrv);
    logic        was_full;
    logic [47:0] head;
    @(negedge clk);
    valid = v; sl = l; sr = r; rdy = rd; mute = mu; lr = lrv;
    @(posedge clk);
    was_full = (m_q.size() == DEPTH);
    m_audio  = lrv ? word_of(m_hl) : word_of(m_hr);
    if (rd) begin
      if (m_q.size() == 0) begin
        m_hl = 24'h0; m_hr = 24'h0;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        head = m_q.pop_front();
        if (mu) begin
          m_hl = 24'h0; m_hr = 24'h0;
        end else begin
          m_hl = head[47:24]; m_hr = head[23:0];
        end
      end
    end
    if (v && !was_full) m_q.push_back({l, r});
    #1;
    check_all();
  endtask

  task automatic idle(input logic lrv);
    step(1'b0, 24'h0, 24'h0, 1'b0, 1'b0, lrv);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    valid = 1'b0; sl = 24'h0; sr = 24'h0; mute = 1'b0; rdy = 1'b0; lr = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst_n = 1'b1;

    // Underrun from reset: silence on both channels
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("urun_l", audio, 32'h0);
    idle(1'b0);
    chk("urun_r", audio, 32'h0);
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    chk("urun_cnt", 32'(ucnt), 32'd1);
`else
    chk("urun_cnt", 32'(ucnt), 32'd0);
`endif

    // Single pair format check
    step(1'b1, 24'h123456, 24'hFEDCBA, 1'b0, 1'b0, 1'b1);
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("fmt_l", audio, 32'h12345600);
    idle(1'b0);
    chk("fmt_r", audio, 32'hFEDCBA00);
    chk("fmt_fill", 32'(fill), 32'd0);

    // Fill to full, reject a 17th push, drain in order, then underrun
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 24'(32'h100000 + i), 24'(32'hA00000 + i), 1'b0, 1'b0, 1'b0);
    chk("full_ready", 32'(ready), 32'd0);
    chk("full_fill", 32'(fill), 32'd16);
    step(1'b1, 24'h777777, 24'h888888, 1'b0, 1'b0, 1'b0);
    chk("full_reject", 32'(fill), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1);
      idle(1'b1);
      chk("drain_l", audio, word_of(24'(32'h100000 + i)));
    end
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("drain_urun", audio, 32'h0);

    // Push and pop together on an empty FIFO
    step(1'b1, 24'h0ABCDE, 24'hF12345, 1'b1, 1'b0, 1'b0);
    chk("pp_fill", 32'(fill), 32'd1);
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("pp_r", audio, 32'hF1234500);

    // Mute pops without output and without counting an underrun
    step(1'b1, 24'h111111, 24'h211111, 1'b0, 1'b0, 1'b1);
    step(1'b1, 24'h322222, 24'h422222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 24'h533333, 24'h633333, 1'b0, 1'b0, 1'b1);
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    chk("mute_out", audio, 32'h0);
    chk("mute_fill", 32'(fill), 32'd2);
    step(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("mute_next", audio, 32'h32222200);

    // Asynchronous reset while the output is non-zero
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_audio", audio, 32'h0);
    check_all();
    @(negedge clk); rst_n = 1'b1;
    idle(1'b0);

    // Randomised traffic with varying push pressure
    for (int ph = 0; ph < 6; ph++) begin
      int pv;
      pv = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 15 : 50);
      for (int c = 0; c < 120; c++) begin
        step(($urandom_range(0, 99) < pv) ? 1'b1 : 1'b0,
             24'($urandom), 24'($urandom),
             ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
             1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
